// File: rtl/operand_loader_pkg.sv
// Shared constants for the operand loader: load-phase encoding and debounce default.
package operand_loader_pkg;

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_CIN  = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  // 20 ms at a 50 MHz board clock.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // The encoding is a plain 2-bit ring, so the wrap from S_DONE to S_A is free.
  function automatic logic [1:0] next_phase(input logic [1:0] cur);
    return cur + 2'd1;
  endfunction

endpackage

// File: rtl/operand_loader_key_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stable-level debounce counter and
// a registered one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_mismatch;
  logic          w_accept;

  assign w_mismatch = (r_sync2 != r_level);
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);

  // NOTE: every flop here uses <= so all of them sample the pre-edge values of
  // each other; a blocking '=' would collapse the synchronizer into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      // A mismatch while released can only mean the key went low, so an
      // accept from level 1 is exactly a press; releases stay silent.
      r_press <= w_accept && r_level;
      if (!w_mismatch) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule

// File: rtl/operand_loader.sv
// Captures A, B and carry-in from the switches, one operand per debounced key
// press, cycling A -> B -> CIN -> DONE -> A.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [3:0] sw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       Carry_In,
  output logic [1:0] phase,
  output logic       operands_valid,
  output logic       press
);

  logic       w_press;
  logic [1:0] r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic       r_cin;
  logic       r_valid;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_press) begin
      case (r_state)
        S_A:     r_a   <= sw;
        S_B:     r_b   <= sw;
        S_CIN:   r_cin <= sw[0];
        default: ;
      endcase
      r_state <= next_phase(r_state);
      // Valid is its own flop so it changes on the same edge as phase.
      r_valid <= (next_phase(r_state) == S_DONE);
    end
  end

  assign A              = r_a;
  assign B              = r_b;
  assign Carry_In       = r_cin;
  assign phase          = r_state;
  assign operands_valid = r_valid;
  assign press          = w_press;

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader with a short debounce window and a
// cycle-level reference model of key acceptance and operand capture.
module tb_operand_loader;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_n;
  logic [3:0] sw;
  logic [3:0] A;
  logic [3:0] B;
  logic       Carry_In;
  logic [1:0] phase;
  logic       operands_valid;
  logic       press;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_press = 0;
  int press_cyc = -1;

  always #5 clk = ~clk;

  operand_loader #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_n          (key_n),
    .sw             (sw),
    .A              (A),
    .B              (B),
    .Carry_In       (Carry_In),
    .phase          (phase),
    .operands_valid (operands_valid),
    .press          (press)
  );

  // Reference: raw key samples per edge; the key reaches the comparison two
  // edges late, and the level flips once D consecutive compared samples
  // all disagree with it.
  bit         m_hist [0:15];
  bit         m_level;
  bit         m_press;
  int         m_phase;
  logic [3:0] m_a;
  logic [3:0] m_b;
  bit         m_cin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_hist[i] = 1'b1;
      m_level = 1'b1;
      m_press = 1'b0;
      m_phase = 0;
      m_a     = 4'h0;
      m_b     = 4'h0;
      m_cin   = 1'b0;
    end else begin : model_step
      bit all_diff;
      bit new_level;
      all_diff = 1'b1;
      for (int i = 1; i <= D; i++)
        if (m_hist[i] == m_level) all_diff = 1'b0;
      new_level = all_diff ? ~m_level : m_level;
      if (m_press) begin
        if (m_phase == 0) m_a = sw;
        else if (m_phase == 1) m_b = sw;
        else if (m_phase == 2) m_cin = sw[0];
        m_phase = (m_phase + 1) % 4;
      end
      m_press = m_level && !new_level;
      m_level = new_level;
      for (int i = 15; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = key_n;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("A", 32'(A), 32'(m_a));
    check("B", 32'(B), 32'(m_b));
    check("Carry_In", 32'(Carry_In), 32'(m_cin));
    check("phase", 32'(phase), 32'(m_phase));
    check("operands_valid", 32'(operands_valid), 32'(m_phase == 3));
    check("press", 32'(press), 32'(m_press));
    if (press === 1'b1) begin
      n_press++;
      press_cyc = cyc;
    end
  endtask

  // One cycle: compare at the falling edge, then drive the next inputs.
  task automatic step(input logic k, input logic [3:0] s);
    @(negedge clk);
    cyc++;
    compare_all();
    key_n = k;
    sw    = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_A", 32'(A), 32'h0);
    check("rst_B", 32'(B), 32'h0);
    check("rst_cin", 32'(Carry_In), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_valid", 32'(operands_valid), 32'h0);
    check("rst_press", 32'(press), 32'h0);
    key_n = 1'b1;
    step(1'b1, sw);
    step(1'b1, sw);
    rst_n = 1'b1;
  endtask

  task automatic press_once(input logic [3:0] s);
    repeat (8) step(1'b0, s);
    repeat (8) step(1'b1, s);
  endtask

  int lat;
  int s_low;

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 4'h0;
    #1;
    check("init_phase", 32'(phase), 32'h0);
    check("init_valid", 32'(operands_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Held key: exactly one press, A loaded.
    do_reset();
    n_press = 0;
    repeat (10) step(1'b0, 4'hA);
    step(1'b1, 4'hA);
    check("hold_presses", 32'(n_press), 32'd1);
    check("hold_A", 32'(A), 32'hA);
    check("hold_phase", 32'(phase), 32'h1);
    check("hold_valid", 32'(operands_valid), 32'h0);
    repeat (8) step(1'b1, 4'hA);

    // Full sequence then wrap.
    do_reset();
    press_once(4'h3);
    press_once(4'h9);
    press_once(4'h1);
    check("seq_A", 32'(A), 32'h3);
    check("seq_B", 32'(B), 32'h9);
    check("seq_cin", 32'(Carry_In), 32'h1);
    check("seq_phase", 32'(phase), 32'h3);
    check("seq_valid", 32'(operands_valid), 32'h1);
    press_once(4'h5);
    check("wrap_phase", 32'(phase), 32'h0);
    check("wrap_valid", 32'(operands_valid), 32'h0);
    check("wrap_A", 32'(A), 32'h3);
    check("wrap_B", 32'(B), 32'h9);
    check("wrap_cin", 32'(Carry_In), 32'h1);

    // Short glitch is rejected.
    n_press = 0;
    repeat (3) step(1'b0, 4'h7);
    repeat (10) step(1'b1, 4'h7);
    check("glitch_presses", 32'(n_press), 32'd0);
    check("glitch_phase", 32'(phase), 32'h0);
    check("glitch_A", 32'(A), 32'h3);

    // Bounce for 20 cycles, then stable low.
    n_press = 0;
    press_cyc = -1;
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) != 0, 4'h4);
    step(1'b0, 4'h4);
    s_low = cyc;
    repeat (12) step(1'b0, 4'h4);
    lat = press_cyc - s_low;
    check("bounce_presses", 32'(n_press), 32'd1);
    check("bounce_latency_in_6_to_8", 32'(lat >= 6 && lat <= 8), 32'd1);
    repeat (10) step(1'b1, 4'h4);

    // Reset in CIN phase, and reset mid-debounce.
    do_reset();
    press_once(4'h5);
    press_once(4'h6);
    check("pre_rst_phase", 32'(phase), 32'h2);
    do_reset();
    press_once(4'h7);
    check("post_rst_A", 32'(A), 32'h7);
    check("post_rst_phase", 32'(phase), 32'h1);
    repeat (3) step(1'b0, 4'h8);
    do_reset();
    press_once(4'h2);
    check("middeb_A", 32'(A), 32'h2);
    check("middeb_phase", 32'(phase), 32'h1);

    // Switch activity with no key.
    n_press = 0;
    for (int i = 0; i < 100; i++) step(1'b1, (i % 2 != 0) ? 4'hF : 4'h0);
    check("idle_presses", 32'(n_press), 32'd0);
    check("idle_A", 32'(A), 32'h2);
    check("idle_B", 32'(B), 32'h0);
    check("idle_cin", 32'(Carry_In), 32'h0);

    // Randomized key runs and switches against the model.
    for (int r = 0; r < 400; r++) begin
      logic k;
      int   len;
      k   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 60) == 0) do_reset();
      for (int j = 0; j < len; j++) step(k, 4'($urandom));
    end
    repeat (10) step(1'b1, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
- REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz), meaning the number of consecutive stable cycles required before a key level change is accepted; legal range 1..2^24-1.
- REQ-002 SHALL have port clk, input, 1, the single clock for all sequential logic.
- REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
- REQ-004 SHALL have port key_n, input, 1, active-low asynchronous pushbutton used to load an operand.
- REQ-005 SHALL have port sw, input, 4, switch value to be captured.
- REQ-006 SHALL have port A, output, 4, captured operand A, feeding the full-adder display stage.
- REQ-007 SHALL have port B, output, 4, captured operand B, feeding the full-adder display stage.
- REQ-008 SHALL have port Carry_In, output, 1, captured carry-in, feeding the full-adder display stage.
- REQ-009 SHALL have port phase, output, 2, current load phase: 00 = A, 01 = B, 10 = CIN, 11 = DONE.
- REQ-010 SHALL have port operands_valid, output, 1, high only while phase is DONE.
- REQ-011 SHALL have port press, output, 1, single-cycle pulse per accepted key press (debug/LED).

Function
- REQ-012 SHALL pass key_n through a 2-flop synchronizer before any other use.
- REQ-013 SHALL hold a debounced level, reset value 1 (released), and a counter that increments while the synchronized key differs from the debounced level and clears to 0 in any cycle they are equal.
- REQ-014 SHALL set the debounced level to the synchronized value in the cycle after the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, then clear the counter.
- REQ-015 SHALL assert press for exactly one cycle on each 1->0 transition of the debounced level; a 0->1 transition (release) SHALL produce no pulse.
- REQ-016 SHALL NOT allow a glitch shorter than DEBOUNCE_CYCLES cycles to change the debounced level or to produce a pulse.
- REQ-017 SHALL implement the FSM S_A -> S_B -> S_CIN -> S_DONE -> S_A, advancing only in a cycle where press=1.
- REQ-018 SHALL, on press in S_A, register sw into A; on press in S_B, register sw into B; on press in S_CIN, register sw[0] into Carry_In.
- REQ-019 SHALL, on press in S_DONE, return to S_A without modifying A, B, or Carry_In.
- REQ-020 SHALL make captured values visible on A, B, and Carry_In in the cycle after press; phase and operands_valid SHALL update in the same cycle.
- REQ-021 SHALL hold A, B, and Carry_In constant in every cycle without press, regardless of sw activity.
- REQ-022 SHALL register all outputs, with no combinational path from sw or key_n to any output.
- REQ-023 SHALL capture exactly one operand per press when the key is held indefinitely.

Reset
- REQ-024 SHALL, on rst_n low, asynchronously force A=0, B=0, Carry_In=0, phase=00 (S_A), operands_valid=0, press=0, debounced level=1, counter=0, and synchronizer flops=1.
- REQ-025 SHALL, when reset is asserted mid-sequence (any phase, including mid-debounce), discard partial progress; after release, the next accepted press loads A.
- REQ-026 SHALL release reset synchronously to clk, provided by the board-level reset synchronizer; this block does not re-synchronize rst_n.

Structure
- REQ-027 SHALL place the FSM state encoding (S_A=00, S_B=01, S_CIN=10, S_DONE=11) and the default DEBOUNCE_CYCLES constant in the shared package operand_loader_pkg; phase SHALL output the state encoding directly.
- REQ-028 SHALL implement the synchronizer, debounce counter, and press edge detect as sub-module key_debounce (ports clk, rst_n, key_n, press), reusable for other board keys.
- REQ-029 SHALL size the counter as ceil(log2(DEBOUNCE_CYCLES+1)) bits.

Verification (DEBOUNCE_CYCLES=4)
- REQ-030 SHALL cover: reset, then key_n low for 10 cycles with sw=4'hA -> exactly one press pulse; A=4'hA, phase=01, operands_valid=0.
- REQ-031 SHALL cover: three clean presses with sw=3, 9, 1 in turn -> A=3, B=9, Carry_In=1, phase=11, operands_valid=1; a fourth press -> phase=00, valid=0, A/B/Carry_In unchanged.
- REQ-032 SHALL cover: key_n pulsed low for 3 cycles, then high -> no press pulse; phase and A unchanged.
- REQ-033 SHALL cover: bouncing low/high every 2 cycles for 20 cycles, then stable low -> exactly one press, occurring 2 + 4 + 1 cycles after the stable-low edge (±1 for sync phase).
- REQ-034 SHALL cover: rst_n asserted in phase 10 with A=5, B=6 -> all outputs 0 immediately (asynchronously); after release, the next press loads A.
- REQ-035 SHALL cover: sw toggling every cycle with no key activity for 100 cycles -> A, B, and Carry_In constant; press never asserts.
